// File: rtl/arb_rr.sv
// arb_rr: registered N-way arbiter with a valid/ack grant handshake.
// Supports fixed priority (RR=0) and round-robin rotating priority (RR=1).
// The search direction is set by FROM_LSB. A grant is held until the consumer
// acks it, the requester withdraws, or lock keeps it for another transfer.
module arb_rr #(
   parameter int N        = 8,
   parameter bit FROM_LSB = 1'b1,
   parameter bit RR       = 1'b1,
   parameter int IDX_W    = $clog2(N)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [N-1:0]     i_req,
   input  logic             i_ack,
   input  logic             i_lock,
   output logic             o_gnt_vld,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] PTR_RST = FROM_LSB ? '0 : LAST;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             gntVld_q, gntVld_d;
   logic [IDX_W-1:0] gntIdx_q, gntIdx_d;
   logic [N-1:0]     gnt_q, gnt_d;

   logic [IDX_W-1:0] ackPtr;
   logic [IDX_W:0]   idleWin;
   logic [IDX_W:0]   ackWin;

   // The slot one beyond idx in the rotation direction, wrapping at either end.
   function automatic logic [IDX_W-1:0] stepPtr(input logic [IDX_W-1:0] idx);
      if (FROM_LSB) begin
         return (idx == LAST) ? '0 : idx + 1'b1;
      end else begin
         return (idx == '0) ? LAST : idx - 1'b1;
      end
   endfunction

   // The first set request starting at ptr and walking once around the ring.
   // The result is {found, index}.
   function automatic logic [IDX_W:0] findWinner(input logic [N-1:0]     req,
                                                  input logic [IDX_W-1:0] ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] slotIdx;
      int               slot;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (FROM_LSB) begin
            slot = (int'(ptr) + k) % N;
         end else begin
            slot = (int'(ptr) - k + N) % N;
         end
         slotIdx = IDX_W'(slot);
         if (!found && req[slotIdx]) begin
            found = 1'b1;
            idx   = slotIdx;
         end
      end
      return {found, idx};
   endfunction

   // Next-state logic. On a completed (unlocked) ack the pointer moves first,
   // and the same cycle re-arbitrates from the new pointer. This lets a
   // waiting client take over without an idle bubble. A withdrawn request
   // leaves the pointer alone, so the same client keeps its turn later.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gntVld_d = gntVld_q;
      gntIdx_d = gntIdx_q;
      ackPtr   = RR ? stepPtr(gntIdx_q) : PTR_RST;
      idleWin  = findWinner(i_req, ptr_q);
      ackWin   = findWinner(i_req, ackPtr);
      unique case (state_q)
         IDLE: begin
            if (idleWin[IDX_W]) begin
               state_d  = GRANT;
               gntVld_d = 1'b1;
               gntIdx_d = idleWin[IDX_W-1:0];
            end
         end
         GRANT: begin
            if (!i_req[gntIdx_q] && !i_ack) begin
               state_d  = IDLE;
               gntVld_d = 1'b0;
               gntIdx_d = '0;
            end else if (i_ack && i_lock) begin
               state_d = GRANT;
            end else if (i_ack) begin
               ptr_d = ackPtr;
               if (ackWin[IDX_W]) begin
                  state_d  = GRANT;
                  gntIdx_d = ackWin[IDX_W-1:0];
               end else begin
                  state_d  = IDLE;
                  gntVld_d = 1'b0;
                  gntIdx_d = '0;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            gntVld_d = 1'b0;
            gntIdx_d = '0;
         end
      endcase
      gnt_d = N'(gntVld_d) << gntIdx_d;
   end

   // State, pointer and all outputs are registered. Reset clears them at once.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= IDLE;
         ptr_q    <= PTR_RST;
         gntVld_q <= 1'b0;
         gntIdx_q <= '0;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gntVld_q <= gntVld_d;
         gntIdx_q <= gntIdx_d;
         gnt_q    <= gnt_d;
      end
   end

   assign o_gnt_vld = gntVld_q;
   assign o_gnt     = gnt_q;
   assign o_gnt_idx = gntIdx_q;

   // Grant outputs must stay mutually consistent on every cycle.
   aOneHot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(o_gnt));
   aVldAny: assert property (@(posedge clk) disable iff (!arst_n) o_gnt_vld == (|o_gnt));
   aIdxGnt: assert property (@(posedge clk) disable iff (!arst_n)
                             o_gnt == (N'(o_gnt_vld) << o_gnt_idx));

endmodule

// File: tb/tb_arb_rr.sv
// tb_arb_rr: directed self-checking bench for arb_rr.
// There are three N=4 instances. DUT 0 is round-robin from the LSB, DUT 1 is
// fixed priority and DUT 2 is round-robin from the MSB. Expected grants are
// queued as each step is driven and checked after the next clock edge.
module tb_arb_rr;

   typedef struct {
      int         dut;
      string      tag;
      logic [6:0] val;
   } exp_t;

   logic       clk;
   logic       arst_n;
   logic [3:0] reqA, reqB, reqC;
   logic       ackA, ackB, ackC;
   logic       lockA, lockB, lockC;
   logic       vldA, vldB, vldC;
   logic [3:0] gntA, gntB, gntC;
   logic [1:0] idxA, idxB, idxC;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   arb_rr #(.N(4), .FROM_LSB(1'b1), .RR(1'b1)) dutA (
      .clk(clk), .arst_n(arst_n), .i_req(reqA), .i_ack(ackA), .i_lock(lockA),
      .o_gnt_vld(vldA), .o_gnt(gntA), .o_gnt_idx(idxA));

   arb_rr #(.N(4), .FROM_LSB(1'b1), .RR(1'b0)) dutB (
      .clk(clk), .arst_n(arst_n), .i_req(reqB), .i_ack(ackB), .i_lock(lockB),
      .o_gnt_vld(vldB), .o_gnt(gntB), .o_gnt_idx(idxB));

   arb_rr #(.N(4), .FROM_LSB(1'b0), .RR(1'b1)) dutC (
      .clk(clk), .arst_n(arst_n), .i_req(reqC), .i_ack(ackC), .i_lock(lockC),
      .o_gnt_vld(vldC), .o_gnt(gntC), .o_gnt_idx(idxC));

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case the run is ever stuck.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input int d, input logic [3:0] req,
                                input logic ack, input logic lock);
      case (d)
         0:       begin reqA = req; ackA = ack; lockA = lock; end
         1:       begin reqB = req; ackB = ack; lockB = lock; end
         default: begin reqC = req; ackC = ack; lockC = lock; end
      endcase
   endtask

   task automatic pushExpect(input int d, input string tag,
                             input logic vld, input logic [1:0] idx);
      exp_t       e;
      logic [3:0] g;
      g     = vld ? (4'b0001 << idx) : 4'b0000;
      e.dut = d;
      e.tag = tag;
      e.val = {vld, idx, g};
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic [6:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.dut)
            0:       obs = {vldA, idxA, gntA};
            1:       obs = {vldB, idxB, gntB};
            default: obs = {vldC, idxC, gntC};
         endcase
         vectors++;
         assert (obs === e.val) else begin
            miscompares++;
            $error("[TB] FAIL %s dut%0d: observed vld/idx/gnt=%b expected %b",
                   e.tag, e.dut, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Directed sequence of steps covering every grant scenario.
   initial begin
      logic [1:0] rrSeq [5];
      logic [1:0] dnSeq [4];
      rrSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      dnSeq = '{2'd3, 2'd0, 2'd3, 2'd0};

      arst_n = 1'b0;
      for (int d = 0; d < 3; d++) applyStimulus(d, 4'b0000, 1'b0, 1'b0);
      #2;
      for (int d = 0; d < 3; d++) pushExpect(d, "reset", 1'b0, 2'd0);
      checkOutput();
      @(posedge clk);
      #1;
      arst_n = 1'b1;

      applyStimulus(0, 4'b1111, 1'b1, 1'b0);
      applyStimulus(1, 4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         pushExpect(0, "rr_rotate", 1'b1, rrSeq[i]);
         pushExpect(1, "fixed_prio", 1'b1, 2'd0);
         tick();
      end

      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1, 4'b0000, 1'b0, 1'b0);
      pushExpect(0, "withdraw_a", 1'b0, 2'd0);
      pushExpect(1, "withdraw_b", 1'b0, 2'd0);
      tick();

      applyStimulus(0, 4'b0000, 1'b1, 1'b0);
      pushExpect(0, "ack_idle", 1'b0, 2'd0);
      tick();

      applyStimulus(0, 4'b0110, 1'b0, 1'b0);
      pushExpect(0, "first_grant", 1'b1, 2'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         pushExpect(0, "hold", 1'b1, 2'd1);
         tick();
      end
      applyStimulus(0, 4'b0110, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         pushExpect(0, "lock", 1'b1, 2'd1);
         tick();
      end
      applyStimulus(0, 4'b0110, 1'b1, 1'b0);
      pushExpect(0, "after_lock", 1'b1, 2'd2);
      tick();

      applyStimulus(0, 4'b0010, 1'b0, 1'b0);
      pushExpect(0, "drop_req", 1'b0, 2'd0);
      tick();
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      pushExpect(0, "idle", 1'b0, 2'd0);
      tick();
      applyStimulus(0, 4'b1100, 1'b0, 1'b0);
      pushExpect(0, "ptr_kept", 1'b1, 2'd2);
      tick();
      applyStimulus(0, 4'b1100, 1'b1, 1'b0);
      pushExpect(0, "rr_next", 1'b1, 2'd3);
      tick();
      applyStimulus(0, 4'b0000, 1'b1, 1'b0);
      pushExpect(0, "ack_empty", 1'b0, 2'd0);
      tick();
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);

      applyStimulus(2, 4'b1001, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         pushExpect(2, "down_wrap", 1'b1, dnSeq[i]);
         tick();
      end
      applyStimulus(2, 4'b0000, 1'b1, 1'b0);
      pushExpect(2, "down_empty", 1'b0, 2'd0);
      tick();
      applyStimulus(2, 4'b0000, 1'b0, 1'b0);

      applyStimulus(0, 4'b1111, 1'b1, 1'b0);
      pushExpect(0, "pre_reset0", 1'b1, 2'd0);
      tick();
      pushExpect(0, "pre_reset1", 1'b1, 2'd1);
      tick();
      applyStimulus(0, 4'b1111, 1'b0, 1'b0);
      pushExpect(0, "pre_reset_hold", 1'b1, 2'd1);
      tick();
      #3;
      arst_n = 1'b0;
      #1;
      pushExpect(0, "async_reset", 1'b0, 2'd0);
      checkOutput();
      #2;
      arst_n = 1'b1;
      pushExpect(0, "post_reset", 1'b1, 2'd0);
      tick();

      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      pushExpect(0, "final_idle", 1'b0, 2'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
